// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types and constants for the 1x3 packet router.
//               - state_t      : router FSM state encoding
//               - ADDR_INVALID : header address that is silently dropped
//               - DEF_*        : default sizing for the router and its FIFOs
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_TIMEOUT    = 30;
    localparam int NUM_PORTS      = 3;

    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_DECODE     = 3'd0,
        ST_WAIT_EMPTY = 3'd1,
        ST_LOAD       = 3'd2,
        ST_DROP       = 3'd3,
        ST_CHECK      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_fifo
// Description : Synchronous FIFO for one router output port.
//               Ports:
//                 clock, reset   - clock, synchronous active-high reset
//                 soft_reset     - flush pointers/count/dout (timeout flush)
//                 we, din        - write request and data
//                 re             - pop request; dout updates on the pop edge
//                 dout           - last popped byte (held otherwise)
//                 empty, full    - status; full drops while a pop is pending
// Revision    : 1.0 - initial release
// ============================================================================
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic [DATA_W-1:0] r_dout;

    logic w_do_rd;
    logic w_do_wr;
    logic w_at_cap;

    assign w_do_rd  = re && (r_count != '0);
    assign w_at_cap = (r_count == (PTR_W+1)'(DEPTH));
    // A pop in the same cycle frees a slot, so full is released combinationally.
    assign full     = w_at_cap && !w_do_rd;
    assign w_do_wr  = we && !full;
    assign empty    = (r_count == '0);
    assign dout     = r_dout;

    always_ff @(posedge clock) begin
        if (w_do_wr) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_rd) begin
                r_dout <= r_mem[r_rptr];
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_modport.sv
`default_nettype none
// ============================================================================
// Module      : router_modport
// Description : 1-input / 3-output byte-serial packet router.
//               Header byte: addr = [1:0], length = [7:2]. Payload follows
//               while pkt_valid is high; the first byte with pkt_valid low is
//               the parity byte (XOR of header and payload).
//               Ports:
//                 clock, reset           - clock, synchronous active-high reset
//                 data_in, pkt_valid     - source byte stream
//                 busy                   - source must hold data_in
//                 err                    - parity mismatch on last packet
//                 read_enb_i             - destination i pops a byte
//                 valid_out_i            - FIFO i not empty
//                 data_out_i             - byte popped from FIFO i
// Revision    : 1.0 - initial release
// ============================================================================
module router_modport
    import router_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pkt_valid,
    output logic              busy,
    output logic              err,
    input  logic              read_enb_0,
    input  logic              read_enb_1,
    input  logic              read_enb_2,
    output logic              valid_out_0,
    output logic              valid_out_1,
    output logic              valid_out_2,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_addr;
    logic [DATA_W-1:0] r_parity;
    logic [DATA_W-1:0] r_rx_parity;
    logic              r_err;

    logic [1:0]            w_hdr_addr;
    logic [NUM_PORTS-1:0]  w_re;
    logic [NUM_PORTS-1:0]  w_empty;
    logic [NUM_PORTS-1:0]  w_full;
    logic [NUM_PORTS-1:0]  w_we;
    logic [NUM_PORTS-1:0]  w_soft;
    logic [DATA_W-1:0]     w_dout [NUM_PORTS];

    logic       w_wr_en;
    logic [1:0] w_wr_port;
    logic       w_hdr_accept;
    logic       w_load_byte;
    logic       w_load_parity;

    assign w_hdr_addr = data_in[1:0];
    assign w_re       = {read_enb_2, read_enb_1, read_enb_0};

    assign valid_out_0 = !w_empty[0];
    assign valid_out_1 = !w_empty[1];
    assign valid_out_2 = !w_empty[2];
    assign data_out_0  = w_dout[0];
    assign data_out_1  = w_dout[1];
    assign data_out_2  = w_dout[2];
    assign err         = r_err;

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            logic [CNT_W-1:0] r_cnt;

            assign w_we[i]   = w_wr_en && (w_wr_port == 2'(i));
            // Counter sitting at TIMEOUT flushes the FIFO on the next edge.
            assign w_soft[i] = (r_cnt == CNT_W'(TIMEOUT));

            always_ff @(posedge clock) begin
                if (reset || w_soft[i]) begin
                    r_cnt <= '0;
                end else if (!w_empty[i] && !w_re[i]) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_cnt <= '0;
                end
            end

            router_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clock      (clock),
                .reset      (reset),
                .soft_reset (w_soft[i]),
                .we         (w_we[i]),
                .din        (data_in),
                .re         (w_re[i]),
                .dout       (w_dout[i]),
                .empty      (w_empty[i]),
                .full       (w_full[i])
            );
        end
    endgenerate

    always_comb begin
        w_next        = r_state;
        busy          = 1'b0;
        w_wr_en       = 1'b0;
        w_wr_port     = r_addr;
        w_hdr_accept  = 1'b0;
        w_load_byte   = 1'b0;
        w_load_parity = 1'b0;
        case (r_state)
            ST_DECODE: begin
                if (pkt_valid) begin
                    if (w_hdr_addr == ADDR_INVALID) begin
                        w_next = ST_DROP;
                    end else if (w_empty[w_hdr_addr]) begin
                        w_wr_en      = 1'b1;
                        w_wr_port    = w_hdr_addr;
                        w_hdr_accept = 1'b1;
                        w_next       = ST_LOAD;
                    end else begin
                        w_next = ST_WAIT_EMPTY;
                    end
                end
            end
            ST_WAIT_EMPTY: begin
                busy = 1'b1;
                // A flushed destination abandons the held packet.
                if (w_soft[r_addr]) begin
                    w_next = pkt_valid ? ST_DROP : ST_DECODE;
                end else if (w_empty[r_addr]) begin
                    w_wr_en      = 1'b1;
                    w_hdr_accept = 1'b1;
                    w_next       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_soft[r_addr]) begin
                    w_next = pkt_valid ? ST_DROP : ST_DECODE;
                end else begin
                    busy = w_full[r_addr];
                    if (!w_full[r_addr]) begin
                        w_wr_en = 1'b1;
                        if (pkt_valid) begin
                            w_load_byte = 1'b1;
                        end else begin
                            w_load_parity = 1'b1;
                            w_next        = ST_CHECK;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!pkt_valid) begin
                    w_next = ST_DECODE;
                end
            end
            ST_CHECK: begin
                busy   = 1'b1;
                w_next = ST_DECODE;
            end
            default: begin
                w_next = ST_DECODE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_DECODE;
            r_addr      <= '0;
            r_parity    <= '0;
            r_rx_parity <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE && pkt_valid && w_hdr_addr != ADDR_INVALID) begin
                r_addr <= w_hdr_addr;
            end
            if (w_hdr_accept) begin
                r_parity <= data_in;
                r_err    <= 1'b0;
            end
            if (w_load_byte) begin
                r_parity <= r_parity ^ data_in;
            end
            if (w_load_parity) begin
                r_rx_parity <= data_in;
            end
            if (r_state == ST_CHECK) begin
                r_err <= (r_parity != r_rx_parity);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_modport.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_modport
// Description : Self-checking bench for router_modport. Bytes written into
//               each output FIFO are pushed to a per-port queue when driven
//               and popped/compared when the destination reads them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_modport;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       busy;
    logic       err;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       valid_out_0, valid_out_1, valid_out_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clock = ~clock;

    router_modport dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .pkt_valid   (pkt_valid),
        .busy        (busy),
        .err         (err),
        .read_enb_0  (read_enb_0),
        .read_enb_1  (read_enb_1),
        .read_enb_2  (read_enb_2),
        .valid_out_0 (valid_out_0),
        .valid_out_1 (valid_out_1),
        .valid_out_2 (valid_out_2),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .data_out_2  (data_out_2)
    );

    function automatic void push_q(input int p, input logic [7:0] b);
        case (p)
            0: q0.push_back(b);
            1: q1.push_back(b);
            2: q2.push_back(b);
            default: ;
        endcase
    endfunction

    task automatic set_re(input int p, input logic v);
        case (p)
            0: read_enb_0 = v;
            1: read_enb_1 = v;
            default: read_enb_2 = v;
        endcase
    endtask

    function automatic logic [7:0] get_dout(input int p);
        case (p)
            0: return data_out_0;
            1: return data_out_1;
            default: return data_out_2;
        endcase
    endfunction

    // Present one payload/parity byte; it is taken on the first edge with busy low.
    task automatic put_byte(input logic [7:0] b, input logic v);
        int guard;
        guard     = 0;
        data_in   = b;
        pkt_valid = v;
        #4;
        while (busy && guard < 100) begin
            @(negedge clock);
            guard++;
            #4;
        end
        if (busy) begin
            n_cmp++; n_err++;
            $display("FAIL put_byte_busy_timeout: busy=%b required 0", busy);
        end
        @(negedge clock);
    endtask

    // Present a header and hold it while the router reports busy afterwards.
    task automatic send_hdr(input logic [7:0] h);
        int guard;
        guard     = 0;
        data_in   = h;
        pkt_valid = 1'b1;
        @(negedge clock);
        while (busy && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (busy) begin
            n_cmp++; n_err++;
            $display("FAIL send_hdr_busy_timeout: busy=%b required 0", busy);
        end
        if (h[1:0] != 2'd3) push_q(int'(h[1:0]), h);
    endtask

    task automatic send_pkt(input logic [7:0] h, input int n, input logic [7:0] base,
                            input bit use_force, input logic [7:0] force_par);
        logic [7:0] par;
        logic [7:0] b;
        par = h;
        send_hdr(h);
        for (int k = 0; k < n; k++) begin
            b   = base + 8'(k);
            par = par ^ b;
            if (h[1:0] != 2'd3) push_q(int'(h[1:0]), b);
            put_byte(b, 1'b1);
        end
        if (use_force) par = force_par;
        if (h[1:0] != 2'd3) push_q(int'(h[1:0]), par);
        put_byte(par, 1'b0);
        data_in   = 8'h00;
        pkt_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic read_n(input int p, input int n);
        logic [7:0] got;
        logic [7:0] exp;
        for (int k = 0; k < n; k++) begin
            set_re(p, 1'b1);
            @(negedge clock);
            got = get_dout(p);
            n_cmp++;
            case (p)
                0: exp = (q0.size() != 0) ? q0.pop_front() : 8'hxx;
                1: exp = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
                default: exp = (q2.size() != 0) ? q2.pop_front() : 8'hxx;
            endcase
            if (got !== exp) begin
                n_err++;
                $display("FAIL read_port%0d[%0d]: data_out=%h required %h", p, k, got, exp);
            end
        end
        set_re(p, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1; data_in = 8'h00; pkt_valid = 1'b0;
        read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if ({valid_out_2, valid_out_1, valid_out_0} !== 3'b000) begin
            n_err++; $display("FAIL reset_valid: valid_out=%b required 000",
                              {valid_out_2, valid_out_1, valid_out_0}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: busy=%b required 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: err=%b required 0", err); end
        n_cmp++; if ({data_out_0, data_out_1, data_out_2} !== 24'h0) begin
            n_err++; $display("FAIL reset_data: data_out=%h %h %h required 0",
                              data_out_0, data_out_1, data_out_2); end
    endtask

    task automatic test_basic;
        send_pkt(8'h11, 4, 8'h01, 1'b0, 8'h00);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL basic_err: err=%b required 0", err); end
        n_cmp++; if (valid_out_1 !== 1'b1) begin n_err++; $display("FAIL basic_valid: valid_out_1=%b required 1", valid_out_1); end
        n_cmp++; if (q1.size() != 6 || q1[5] !== 8'h15) begin
            n_err++; $display("FAIL basic_model: queue size=%0d required 6", q1.size()); end
        read_n(1, 6);
        n_cmp++; if (valid_out_1 !== 1'b0) begin n_err++; $display("FAIL basic_drained: valid_out_1=%b required 0", valid_out_1); end
    endtask

    task automatic test_parity_err;
        send_pkt(8'h11, 4, 8'h01, 1'b1, 8'h00);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL parity_err_set: err=%b required 1", err); end
        send_hdr(8'h06);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL parity_err_clear: err=%b required 0", err); end
        push_q(2, 8'hAA);
        put_byte(8'hAA, 1'b1);
        push_q(2, 8'h06 ^ 8'hAA);
        put_byte(8'h06 ^ 8'hAA, 1'b0);
        data_in = 8'h00; pkt_valid = 1'b0;
        @(negedge clock);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL parity_good_after: err=%b required 0", err); end
        read_n(1, 6);
        read_n(2, 3);
        n_cmp++; if ({valid_out_2, valid_out_1} !== 2'b00) begin
            n_err++; $display("FAIL parity_drained: valid_out_2/1=%b required 00", {valid_out_2, valid_out_1}); end
    endtask

    task automatic test_wait_empty;
        int guard;
        send_pkt(8'h05, 1, 8'h55, 1'b0, 8'h00);
        data_in = 8'h05; pkt_valid = 1'b1;
        @(negedge clock);
        repeat (3) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wait_busy: busy=%b required 1", busy); end
            @(negedge clock);
        end
        read_n(1, 3);
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wait_release: busy=%b required 0", busy); end
        push_q(1, 8'h05);
        push_q(1, 8'h66);
        put_byte(8'h66, 1'b1);
        push_q(1, 8'h05 ^ 8'h66);
        put_byte(8'h05 ^ 8'h66, 1'b0);
        data_in = 8'h00; pkt_valid = 1'b0;
        @(negedge clock);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL wait_err: err=%b required 0", err); end
        read_n(1, 3);
        n_cmp++; if (valid_out_1 !== 1'b0) begin n_err++; $display("FAIL wait_drained: valid_out_1=%b required 0", valid_out_1); end
    endtask

    task automatic test_full;
        logic [7:0] par;
        logic [7:0] exp;
        send_hdr(8'h3C);
        par = 8'h3C;
        for (int k = 1; k <= 15; k++) begin
            par = par ^ 8'(k);
            push_q(0, 8'(k));
            put_byte(8'(k), 1'b1);
        end
        push_q(0, par);
        data_in = par; pkt_valid = 1'b0;
        repeat (3) begin
            #4;
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy: busy=%b required 1", busy); end
            @(negedge clock);
        end
        read_enb_0 = 1'b1;
        #4;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_release: busy=%b required 0", busy); end
        @(negedge clock);
        read_enb_0 = 1'b0;
        exp = q0.pop_front();
        n_cmp++; if (data_out_0 !== exp) begin n_err++; $display("FAIL full_first_pop: data_out_0=%h required %h", data_out_0, exp); end
        data_in = 8'h00;
        @(negedge clock);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL full_err: err=%b required 0", err); end
        read_n(0, 16);
        n_cmp++; if (valid_out_0 !== 1'b0) begin n_err++; $display("FAIL full_drained: valid_out_0=%b required 0", valid_out_0); end
    endtask

    task automatic test_timeout_drop;
        int guard;
        send_pkt(8'h06, 1, 8'hAA, 1'b0, 8'h00);
        repeat (24) @(negedge clock);
        n_cmp++; if (valid_out_2 !== 1'b1) begin n_err++; $display("FAIL timeout_early: valid_out_2=%b required 1", valid_out_2); end
        guard = 0;
        while (valid_out_2 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        n_cmp++; if (valid_out_2 !== 1'b0) begin n_err++; $display("FAIL timeout_flush: valid_out_2=%b required 0", valid_out_2); end
        n_cmp++; if (data_out_2 !== 8'h00) begin n_err++; $display("FAIL timeout_dout: data_out_2=%h required 00", data_out_2); end
        q2.delete();
        send_pkt(8'h07, 2, 8'h10, 1'b0, 8'h00);
        n_cmp++; if ({valid_out_2, valid_out_1, valid_out_0} !== 3'b000) begin
            n_err++; $display("FAIL drop_valid: valid_out=%b required 000",
                              {valid_out_2, valid_out_1, valid_out_0}); end
        n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin
            n_err++; $display("FAIL drop_status: busy/err=%b%b required 00", busy, err); end
        send_pkt(8'h06, 1, 8'h21, 1'b0, 8'h00);
        read_n(2, 3);
    endtask

    task automatic test_reset_mid;
        send_pkt(8'h11, 4, 8'h01, 1'b1, 8'h00);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL mid_err_set: err=%b required 1", err); end
        send_hdr(8'h08);
        put_byte(8'h01, 1'b1);
        data_in = 8'h02;
        reset   = 1'b1;
        @(negedge clock);
        n_cmp++; if ({valid_out_1, valid_out_0, busy, err} !== 4'b0000) begin
            n_err++; $display("FAIL mid_reset: valid1/valid0/busy/err=%b required 0000",
                              {valid_out_1, valid_out_0, busy, err}); end
        n_cmp++; if (data_out_0 !== 8'h00) begin n_err++; $display("FAIL mid_reset_dout: data_out_0=%h required 00", data_out_0); end
        reset = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
        q0.delete(); q1.delete();
        @(negedge clock);
        send_pkt(8'h04, 1, 8'h99, 1'b0, 8'h00);
        read_n(0, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity_err();
        test_wait_empty();
        test_full();
        test_timeout_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
